proc_core_gen2: RTL and testbench
=================================

// Module: proc_core_gen2
// PURPOSE
//  Parametrised multi-cycle processor core, successor of the lab-2 fixed 16-bit/8-register design.
//  Fetches instructions from an external synchronous memory port, using R[NREG-1] as PC.
//  Adds ld/st, conditional move (mvnz), halt, a run/done handshake and a registered zero flag.
//  Sits between the board top (clock/resetn/run) and a shared instruction/data memory.
// PARAMETERS
//  DW    16  data, register and bus width (>=8)
//  NREG  8   register count, power of 2, 4..16; R[NREG-1] is PC
//  AW    8   memory address width; mem_addr = low AW bits of source value (AW<=DW)
// PORTS
//  clock      in   1       single clock, all state on rising edge
//  resetn     in   1       synchronous, active-low reset
//  run        in   1       level: core executes instructions while high
//  mem_addr   out  AW      memory address, driven from registered ADDR
//  mem_rdata  in   DW      read data, valid the cycle after mem_addr is presented
//  mem_wdata  out  DW      store data (registered DOUT)
//  mem_we     out  1       write strobe, one cycle per st
//  done       out  1       one-cycle pulse at instruction completion
//  halted     out  1       high after halt until reset
//  bus        out  DW      internal bus value, for debug
// BEHAVIOUR
//  Encoding: IR = {op[2:0], rX[RW-1:0], rY[RW-1:0]}, RW=clog2(NREG); IR taken from mem_rdata[3+2RW-1:0].
//  Opcodes: 0 mv rX,rY | 1 mvi rX,#imm (imm = next word) | 2 add | 3 sub | 4 ld rX,[rY] | 5 st rX,[rY]
//           6 mvnz rX,rY (move iff Z==0) | 7 halt.
//  Reset (resetn low at edge): all regs, A, G, ADDR, DOUT, IR = 0; Z=0; state IDLE; done=0,
//    mem_we=0, halted=0. Reset wins over every other event, including mid-instruction.
//  FSM: IDLE -> (run) F0: ADDR<=PC, PC<=PC+1 -> F1: wait -> DEC: IR<=mem_rdata -> execute states -> IDLE/F0.
//  Execute:
//   mv/mvnz  E1: rX<=rY (mvnz: no write if Z==1); done.          total 4 cycles
//   mvi      E1: ADDR<=PC, PC<=PC+1; E2 wait; E3: rX<=mem_rdata; done.  6 cycles
//   add/sub  E1: A<=rX; E2: G<=A+/-rY, Z<=(result==0); E3: rX<=G; done.  6 cycles
//   ld       E1: ADDR<=rY; E2 wait; E3: rX<=mem_rdata; done.     6 cycles
//   st       E1: ADDR<=rY, DOUT<=rX; E2: mem_we=1; done.         5 cycles
//   halt     E1: halted<=1; done; state HALT (absorbing until reset).
//  Arithmetic modulo 2^DW, no carry/overflow out; PC wraps 2^DW-1 -> 0.
//  Write to PC (rX=NREG-1) is a jump; it overrides the increment of that cycle.
//  done is high exactly in the final execute cycle; after it, FSM goes to F0 if run=1, else IDLE.
//  run falling mid-instruction: current instruction completes, then IDLE. run ignored in HALT.
//  Bus mux is one-hot-by-construction: exactly one source (reg, G, mem_rdata) or 0 when none.
//  mem_we never asserts outside st E2; mem_addr holds between updates.
// STRUCTURE
//  Shared package proc_pkg: opcode localparams, FSM state encoding, RW computation function.
//  Sub-module proc_regfile (NREG x DW, one write port, two read ports, PC increment input);
//  FSM, A/G/Z, ADDR/DOUT and bus mux stay in this module.
// TESTING
//  Reset: drive resetn=0 mid-add E2 -> next cycle all regs 0, state IDLE, done=0, mem_we=0.
//  mvi r0,#5; mvi r1,#3; add r0,r1 -> r0=8, Z=0, done pulses at cycles 6,12,18 with run held high.
//  sub r0,r0 then mvnz r2,r1 (r2=0, r1=3) -> Z=1, r2 stays 0; after add giving nonzero, mvnz copies.
//  st r1,[r3] with r3=0x40, r1=0xBEEF -> mem_we=1 for one cycle, mem_addr=0x40, mem_wdata=0xBEEF;
//    ld r4,[r3] -> r4=0xBEEF.
//  mv r7,r5 with r5=0x10 -> next fetch at 0x10 (no +1); PC=0xFFFF fetch -> PC wraps to 0.
//  run dropped during mvi E1 -> instruction completes, done pulses, FSM in IDLE; halt -> halted=1,
//    run toggles ignored, no further mem accesses until resetn.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for proc_core_gen2: opcodes, FSM state codes, bus sources
// and the register-index width helper.
package proc_pkg;

    localparam logic [2:0] OP_MV   = 3'd0;
    localparam logic [2:0] OP_MVI  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_LD   = 3'd4;
    localparam logic [2:0] OP_ST   = 3'd5;
    localparam logic [2:0] OP_MVNZ = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_F0   = 3'd1;
    localparam logic [2:0] ST_F1   = 3'd2;
    localparam logic [2:0] ST_DEC  = 3'd3;
    localparam logic [2:0] ST_E1   = 3'd4;
    localparam logic [2:0] ST_E2   = 3'd5;
    localparam logic [2:0] ST_E3   = 3'd6;
    localparam logic [2:0] ST_HALT = 3'd7;

    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_RX   = 3'd1,
        BUS_RY   = 3'd2,
        BUS_PC   = 3'd3,
        BUS_G    = 3'd4,
        BUS_MEM  = 3'd5
    } bus_sel_e;

    function automatic int reg_w(input int nreg);
        return $clog2(nreg);
    endfunction

endpackage

// File: rtl/proc_regfile.sv
// NREG x DW register file with one write port and two read ports.
// The top register is the PC and has a dedicated increment input.
module proc_regfile #(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int RW   = 3
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          we_i,
    input  logic [RW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pc_inc_i,
    input  logic [RW-1:0] ra_addr_i,
    input  logic [RW-1:0] rb_addr_i,
    output logic [DW-1:0] ra_data_o,
    output logic [DW-1:0] rb_data_o,
    output logic [DW-1:0] pc_o
);

    logic [DW-1:0] regs_q [NREG];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            if (pc_inc_i) regs_q[NREG-1] <= regs_q[NREG-1] + DW'(1);
            // A write to the PC is a jump; being last, it beats the increment.
            if (we_i) regs_q[waddr_i] <= wdata_i;
        end
    end

    assign ra_data_o = regs_q[ra_addr_i];
    assign rb_data_o = regs_q[rb_addr_i];
    assign pc_o      = regs_q[NREG-1];

endmodule

// File: rtl/proc_core_gen2.sv
// Multi-cycle processor core: fetch/decode/execute FSM over a shared synchronous
// memory port, with A/G/Z datapath, ADDR/DOUT registers and a single internal bus.
module proc_core_gen2 import proc_pkg::*; #(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int AW   = 8
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          run,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          done,
    output logic          halted,
    output logic [DW-1:0] bus
);

    localparam int RW = reg_w(NREG);
    localparam int IW = 3 + 2 * RW;

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] ir_q;
    logic [DW-1:0] a_q, g_q, dout_q;
    logic [AW-1:0] addr_q;
    logic          z_q, halted_q;

    logic [2:0]    op;
    logic [RW-1:0] rx, ry;
    logic [DW-1:0] rx_data, ry_data, pc, alu;

    bus_sel_e bus_sel;
    logic     rf_we, pc_inc, ld_ir, ld_addr, ld_dout, ld_a, ld_g, set_halt, fin;

    assign op = ir_q[IW-1 -: 3];
    assign rx = ir_q[2*RW-1 -: RW];
    assign ry = ir_q[RW-1:0];

    proc_regfile #(.DW(DW), .NREG(NREG), .RW(RW)) u_rf (
        .clock     (clock),
        .resetn    (resetn),
        .we_i      (rf_we),
        .waddr_i   (rx),
        .wdata_i   (bus),
        .pc_inc_i  (pc_inc),
        .ra_addr_i (rx),
        .rb_addr_i (ry),
        .ra_data_o (rx_data),
        .rb_data_o (ry_data),
        .pc_o      (pc)
    );

    // Control depends only on state, opcode, Z and run; never on the bus itself.
    always_comb begin
        state_d  = state_q;
        bus_sel  = BUS_NONE;
        rf_we    = 1'b0;
        pc_inc   = 1'b0;
        ld_ir    = 1'b0;
        ld_addr  = 1'b0;
        ld_dout  = 1'b0;
        ld_a     = 1'b0;
        ld_g     = 1'b0;
        set_halt = 1'b0;
        fin      = 1'b0;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_F0;
            ST_F0: begin
                bus_sel = BUS_PC;
                ld_addr = 1'b1;
                pc_inc  = 1'b1;
                state_d = ST_F1;
            end
            ST_F1:  state_d = ST_DEC;
            ST_DEC: begin
                ld_ir   = 1'b1;
                state_d = ST_E1;
            end
            ST_E1: begin
                state_d = ST_E2;
                case (op)
                    OP_MV, OP_MVNZ: begin
                        bus_sel = BUS_RY;
                        rf_we   = (op == OP_MV) || !z_q;
                        fin     = 1'b1;
                    end
                    OP_MVI: begin
                        bus_sel = BUS_PC;
                        ld_addr = 1'b1;
                        pc_inc  = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        bus_sel = BUS_RX;
                        ld_a    = 1'b1;
                    end
                    OP_LD: begin
                        bus_sel = BUS_RY;
                        ld_addr = 1'b1;
                    end
                    OP_ST: begin
                        bus_sel = BUS_RY;
                        ld_addr = 1'b1;
                        ld_dout = 1'b1;
                    end
                    default: begin
                        set_halt = 1'b1;
                        fin      = 1'b1;
                        state_d  = ST_HALT;
                    end
                endcase
            end
            ST_E2: begin
                state_d = ST_E3;
                if (op == OP_ADD || op == OP_SUB) begin
                    bus_sel = BUS_RY;
                    ld_g    = 1'b1;
                end else if (op == OP_ST) begin
                    fin = 1'b1;
                end
            end
            ST_E3: begin
                bus_sel = (op == OP_ADD || op == OP_SUB) ? BUS_G : BUS_MEM;
                rf_we   = 1'b1;
                fin     = 1'b1;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
        if (fin && op != OP_HALT) state_d = run ? ST_F0 : ST_IDLE;
    end

    always_comb begin
        case (bus_sel)
            BUS_RX:  bus = rx_data;
            BUS_RY:  bus = ry_data;
            BUS_PC:  bus = pc;
            BUS_G:   bus = g_q;
            BUS_MEM: bus = mem_rdata;
            default: bus = '0;
        endcase
    end

    assign alu = (op == OP_SUB) ? a_q - bus : a_q + bus;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            ir_q     <= '0;
            a_q      <= '0;
            g_q      <= '0;
            z_q      <= 1'b0;
            addr_q   <= '0;
            dout_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ld_ir)   ir_q   <= mem_rdata[IW-1:0];
            if (ld_addr) addr_q <= bus[AW-1:0];
            if (ld_dout) dout_q <= rx_data;
            if (ld_a)    a_q    <= bus;
            if (ld_g) begin
                g_q <= alu;
                z_q <= (alu == '0);
            end
            if (set_halt) halted_q <= 1'b1;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = dout_q;
    assign mem_we    = (state_q == ST_E2) && (op == OP_ST);
    assign done      = fin;
    assign halted    = halted_q;

endmodule

// File: tb/tb_proc_core_gen2.sv
// Bench for proc_core_gen2: an instruction-level model runs each program alongside
// the core and predicts architectural state, latency and stores per instruction.
module tb_proc_core_gen2;
    import proc_pkg::*;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        run = 1'b0;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = '0;
    logic [15:0] mem_wdata;
    logic [15:0] bus;
    logic        mem_we, done, halted;

    proc_core_gen2 #(.DW(16), .NREG(8), .AW(8)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .run       (run),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .done      (done),
        .halted    (halted),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    logic [15:0] mem [256];
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // instruction-level reference state
    logic [15:0] mr [8];
    logic [15:0] mm [256];
    logic        mz;
    bit          mhalt;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
        return {7'd0, op, x, y};
    endfunction

    task automatic set_word(input int a, input logic [15:0] w);
        mem[a] = w;
        mm[a]  = w;
    endtask

    task automatic model_step(output int lat, output bit is_st, output logic [7:0] sa, output logic [15:0] sd);
        logic [8:0]  ir;
        logic [2:0]  op, x, y;
        logic [15:0] r;
        ir = mm[mr[7][7:0]][8:0];
        mr[7] = mr[7] + 16'd1;
        op = ir[8:6]; x = ir[5:3]; y = ir[2:0];
        is_st = 0; sa = '0; sd = '0;
        case (op)
            3'd0: begin mr[x] = mr[y]; lat = 4; end
            3'd1: begin r = mm[mr[7][7:0]]; mr[7] = mr[7] + 16'd1; mr[x] = r; lat = 6; end
            3'd2: begin r = mr[x] + mr[y]; mz = (r == 16'd0); mr[x] = r; lat = 6; end
            3'd3: begin r = mr[x] - mr[y]; mz = (r == 16'd0); mr[x] = r; lat = 6; end
            3'd4: begin mr[x] = mm[mr[y][7:0]]; lat = 6; end
            3'd5: begin sa = mr[y][7:0]; sd = mr[x]; mm[sa] = sd; is_st = 1; lat = 5; end
            3'd6: begin if (!mz) mr[x] = mr[y]; lat = 4; end
            default: begin mhalt = 1; lat = 4; end
        endcase
    endtask

    task automatic check_arch(input string tag);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_r%0d", tag, i), 32'(dut.u_rf.regs_q[i]), 32'(mr[i]));
        chk({tag, "_z"}, 32'(dut.z_q), 32'(mz));
        chk({tag, "_halted"}, 32'(halted), 32'(mhalt));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mr[i] = '0;
        mz = 1'b0;
        mhalt = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        run = 1'b0;
        repeat (2) @(negedge clock);
        model_reset();
        check_arch("rst");
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        resetn = 1'b1;
    endtask

    // Entered at a negedge; cyc0 is how many cycles of this instruction have already elapsed.
    task automatic exec_one(input int cyc0, input bit drop_mid, input bit drop_end, output bit ok);
        int lat, cyc, nwe;
        bit is_st, seen;
        logic [7:0]  sa;
        logic [15:0] sd;
        model_step(lat, is_st, sa, sd);
        cyc = cyc0; nwe = 0; seen = 0;
        while (!seen && cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (drop_mid && cyc == 4) run = 1'b0;
            if (mem_we) begin
                nwe++;
                chk("st_addr", 32'(mem_addr), 32'(sa));
                chk("st_data", 32'(mem_wdata), 32'(sd));
            end
            if (done) seen = 1;
        end
        ok = seen;
        chk("done_seen", 32'(seen), 32'd1);
        if (!seen) return;
        if (drop_end) run = 1'b0;
        chk("latency", 32'(cyc), 32'(lat));
        chk("we_count", 32'(nwe), 32'(is_st));
        @(negedge clock);
        check_arch("ex");
    endtask

    task automatic run_prog(input int max_instr, input bit rnd_run, input int drop_at);
        int cyc0;
        bit ok, dm, de;
        logic [7:0] a0;
        run = 1'b1;
        cyc0 = 0;
        for (int k = 0; k < max_instr; k++) begin
            dm = (k == drop_at) || (rnd_run && $urandom_range(0, 7) == 0);
            de = !dm && rnd_run && $urandom_range(0, 7) == 0;
            exec_one(cyc0, dm, de, ok);
            if (!ok || mhalt) return;
            if (!run) begin
                a0 = mem_addr;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clock);
                    chk("idle_done", 32'(done), 32'd0);
                    chk("idle_addr", 32'(mem_addr), 32'(a0));
                end
                run = 1'b1;
                cyc0 = 0;
            end else begin
                cyc0 = 1;
            end
        end
    endtask

    task automatic halt_check(input int n);
        logic [7:0] a0;
        a0 = mem_addr;
        repeat (n) begin
            run = 1'($urandom_range(0, 1));
            @(negedge clock);
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_we", 32'(mem_we), 32'd0);
            chk("halt_done", 32'(done), 32'd0);
            chk("halt_addr", 32'(mem_addr), 32'(a0));
        end
    endtask

    initial begin
        bit ok;
        logic [15:0] w;
        for (int i = 0; i < 256; i++) set_word(i, 16'd0);
        do_reset();

        // directed program: arithmetic, Z/mvnz, st/ld, jump, PC wrap, halt
        set_word(0,  enc(OP_MVI, 0, 0));  set_word(1, 16'd5);
        set_word(2,  enc(OP_MVI, 1, 0));  set_word(3, 16'd3);
        set_word(4,  enc(OP_ADD, 0, 1));
        set_word(5,  enc(OP_SUB, 0, 0));
        set_word(6,  enc(OP_MVNZ, 2, 1));
        set_word(7,  enc(OP_ADD, 0, 1));
        set_word(8,  enc(OP_MVNZ, 2, 1));
        set_word(9,  enc(OP_MVI, 3, 0));  set_word(10, 16'h0040);
        set_word(11, enc(OP_MVI, 1, 0));  set_word(12, 16'hBEEF);
        set_word(13, enc(OP_ST, 1, 3));
        set_word(14, enc(OP_LD, 4, 3));
        set_word(15, enc(OP_MVI, 5, 0));  set_word(16, 16'h0020);
        set_word(17, enc(OP_MV, 7, 5));
        set_word(32, enc(OP_MVI, 7, 0));  set_word(33, 16'hFFFF);
        set_word(255, enc(OP_HALT, 0, 0));
        run_prog(40, 0, 7);
        chk("dir_r0", 32'(dut.u_rf.regs_q[0]), 32'h0003);
        chk("dir_r2", 32'(dut.u_rf.regs_q[2]), 32'h0003);
        chk("dir_r4", 32'(dut.u_rf.regs_q[4]), 32'hBEEF);
        chk("dir_pc", 32'(dut.u_rf.regs_q[7]), 32'h0000);
        chk("dir_mem40", 32'(mem[8'h40]), 32'hBEEF);
        chk("dir_halted", 32'(halted), 32'd1);
        halt_check(12);

        // reset asserted during add E2 with Z=1 and r0=5
        do_reset();
        set_word(0, enc(OP_MVI, 0, 0)); set_word(1, 16'd5);
        set_word(2, enc(OP_SUB, 1, 1));
        set_word(3, enc(OP_ADD, 0, 0));
        run = 1'b1;
        exec_one(0, 0, 0, ok);
        exec_one(1, 0, 0, ok);
        repeat (4) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        model_reset();
        check_arch("midrst");
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_we", 32'(mem_we), 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        chk("midrst_bus", 32'(bus), 32'd0);
        chk("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
        resetn = 1'b1;
        run = 1'b0;

        // random programs with random run gaps
        for (int s = 0; s < 12; s++) begin
            do_reset();
            for (int i = 0; i < 256; i++) begin
                w = 16'($urandom);
                if (w[8:6] == 3'd7 && $urandom_range(0, 3) != 0) w[8:6] = 3'($urandom_range(0, 6));
                set_word(i, w);
            end
            run_prog(40, 1, -1);
            if (mhalt) halt_check(4);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
